// File: rtl/boot_pkg.sv
// Shared types and constants for the parametrised UART boot loader.
// The optional checksum stage is enabled with the BOOT_CHECKSUM_EN macro.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CNT_LO  = 3'd1,
        CNT_HI  = 3'd2,
        DATA    = 3'd3,
        CSUM    = 3'd4,
        RESP    = 3'd5,
        WAIT_TX = 3'd6,
        RUN     = 3'd7
    } boot_state_e;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 32'd8;
    endfunction

endpackage

// File: rtl/boot_word_pack.sv
// Assembles little-endian payload bytes into DATA_W-bit words and raises a
// one-cycle strobe with the finished word the clock after its last byte.
module boot_word_pack
    import boot_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              last_byte_o,
    output logic              word_done_o,
    output logic [DATA_W-1:0] word_o
);

    localparam int unsigned BPW      = bytes_per_word(DATA_W);
    localparam int unsigned IDX_W    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] merged_s;

    assign last_byte_o = (byte_idx_q == LAST_IDX);
    assign word_done_o = done_q;
    assign word_o      = word_q;

    // Byte placement and word hand-off.
    always_comb begin
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        word_d     = word_q;
        done_d     = 1'b0;
        merged_s   = asm_q;
        for (int b = 0; b < BPW; b++) begin
            if (byte_idx_q == IDX_W'(b)) begin
                merged_s[8*b +: 8] = byte_i;
            end else begin
                merged_s[8*b +: 8] = asm_q[8*b +: 8];
            end
        end
        if (clr_i) begin
            byte_idx_d = '0;
            asm_d      = '0;
        end else if (byte_valid_i) begin
            if (last_byte_o) begin
                byte_idx_d = '0;
                asm_d      = '0;
                word_d     = merged_s;
                done_d     = 1'b1;
            end else begin
                byte_idx_d = byte_idx_q + IDX_W'(1);
                asm_d      = merged_s;
            end
        end else begin
            byte_idx_d = byte_idx_q;
        end
    end

    // Assembly state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx_q <= '0;
            asm_q      <= '0;
            word_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            word_q     <= word_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: rtl/uart_boot_loader_param.sv
// Framed UART program loader: stalls the core, writes N words, answers ACK/NAK.
// Define BOOT_CHECKSUM_EN to require a trailing mod-256 payload checksum byte.
module uart_boot_loader_param
    import boot_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter logic [31:0] TIMEOUT_CYC = 32'd5_000_000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall_pro,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

    boot_state_e       state_q, state_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       timer_q, timer_d;
    logic              nak_q, nak_d;
    logic              seen_busy_q, seen_busy_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              stall_q, stall_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        sync_s;
    logic        active_s;
    logic        timeout_s;
    logic        pack_clr_s;
    logic        pack_valid_s;
    logic        last_byte_s;
    logic [15:0] count_s;

    assign sync_s       = rx_valid && (rx_data == SYNC_BYTE);
    assign active_s     = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                          (state_q == DATA)   || (state_q == CSUM);
    assign timeout_s    = active_s && !rx_valid &&
                          (({1'b0, timer_q} + 33'd1) >= {1'b0, TIMEOUT_CYC});
    assign pack_clr_s   = sync_s && ((state_q == IDLE) || (state_q == RUN));
    assign pack_valid_s = rx_valid && (state_q == DATA);
    assign count_s      = {rx_data, cnt_lo_q};

    boot_word_pack #(
        .DATA_W (DATA_W)
    ) u_pack (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (pack_clr_s),
        .byte_valid_i (pack_valid_s),
        .byte_i       (rx_data),
        .last_byte_o  (last_byte_s),
        .word_done_o  (mem_we),
        .word_o       (mem_wdata)
    );

    assign mem_addr  = addr_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign stall_pro = stall_q;
    assign load_done = done_q;
    assign load_err  = err_q;

    // Frame sequencing, response generation and inactivity timer.
    always_comb begin
        state_d     = state_q;
        cnt_lo_d    = cnt_lo_q;
        count_d     = count_q;
        word_cnt_d  = word_cnt_q;
        addr_d      = addr_q;
        nak_d       = nak_q;
        seen_busy_d = seen_busy_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        done_d      = done_q;
        err_d       = err_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        if (active_s && !rx_valid) begin
            timer_d = timer_q + 32'd1;
        end else begin
            timer_d = 32'd0;
        end

        case (state_q)
            IDLE, RUN: begin
                if (sync_s) begin
                    state_d = CNT_LO;
                    nak_d   = 1'b0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            CNT_LO: begin
                if (rx_valid) begin
                    cnt_lo_d = rx_data;
                    state_d  = CNT_HI;
                end else if (timeout_s) begin
                    nak_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = CNT_LO;
                end
            end
            CNT_HI: begin
                if (rx_valid) begin
                    count_d    = count_s;
                    word_cnt_d = 16'd0;
                    if ({17'd0, count_s} > DEPTH) begin
                        nak_d   = 1'b1;
                        state_d = RESP;
                    end else if (count_s == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = RESP;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end else if (timeout_s) begin
                    nak_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = CNT_HI;
                end
            end
            DATA: begin
                if (rx_valid) begin
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q + rx_data;
`endif
                    if (last_byte_s) begin
                        addr_d     = ADDR_W'(word_cnt_q);
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_q == (count_q - 16'd1)) begin
`ifdef BOOT_CHECKSUM_EN
                            state_d = CSUM;
`else
                            state_d = RESP;
`endif
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end else if (timeout_s) begin
                    nak_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = DATA;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CSUM: begin
                if (rx_valid) begin
                    nak_d   = (rx_data != csum_q);
                    state_d = RESP;
                end else if (timeout_s) begin
                    nak_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = CSUM;
                end
            end
`endif
            RESP: begin
                if (!tx_busy) begin
                    tx_start_d  = 1'b1;
                    tx_data_d   = nak_q ? NAK_BYTE : ACK_BYTE;
                    seen_busy_d = 1'b0;
                    state_d     = WAIT_TX;
                end else begin
                    state_d = RESP;
                end
            end
            WAIT_TX: begin
                // The transmitter must be seen busy first so the finish is not
                // mistaken for the idle gap before it accepts the request.
                if (tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    if (nak_q) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    state_d = WAIT_TX;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stall_d = (state_d != RUN);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_lo_q    <= 8'd0;
            count_q     <= 16'd0;
            word_cnt_q  <= 16'd0;
            addr_q      <= '0;
            timer_q     <= 32'd0;
            nak_q       <= 1'b0;
            seen_busy_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'd0;
            stall_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_lo_q    <= cnt_lo_d;
            count_q     <= count_d;
            word_cnt_q  <= word_cnt_d;
            addr_q      <= addr_d;
            timer_q     <= timer_d;
            nak_q       <= nak_d;
            seen_busy_q <= seen_busy_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            stall_q     <= stall_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Payload checksum accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

endmodule

// File: doc/uart_boot_loader_param.md
Name: uart_boot_loader_param

Overview:
- Parametrised successor to the fixed 8-bit-address, 32-bit-word UART bootloader.
- Sits between the UART receiver/transmitter and the instruction memory write port of the pipelined core.
- Holds the pipeline stalled, receives a framed program image, writes words to memory, and reports ACK/NAK over UART.
- Adds word count, width and depth parameters, framing, an inactivity timeout, reload from run mode, and an optional checksum.

Parameters:
- DATA_W, 32, instruction word width; multiple of 8, range 8..64.
- ADDR_W, 8, word-address width; memory depth = 2**ADDR_W words.
- TIMEOUT_CYC, 5_000_000, idle clocks between bytes before a load is aborted; range 1..2**32-1.
- SYNC_BYTE, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe; rx_data is valid
- tx_busy  in  1  UART transmitter is busy
- tx_data  out  8  response byte
- tx_start  out  1  one-cycle transmit request
- mem_we  out  1  one-cycle memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  DATA_W  assembled word
- stall_pro  out  1  freeze request to PC and IF/ID registers
- load_done  out  1  last load succeeded; sticky until next SYNC_BYTE
- load_err  out  1  last load failed; sticky until next SYNC_BYTE

Behaviour:
- Reset values: state=IDLE; stall_pro=1; all other outputs 0; word counter, byte counter, timer and checksum 0.
- Frame format: SYNC_BYTE, COUNT_LO, COUNT_HI, then N=COUNT words of DATA_W/8 bytes each, little-endian.
- State transitions:
  - IDLE: rx_valid with SYNC_BYTE -> CNT_LO. Any other byte is ignored.
  - CNT_LO -> CNT_HI on the next byte.
  - At CNT_HI:
    - N > 2**ADDR_W -> RESP with NAK.
    - N = 0 -> CSUM if checksum is enabled, else RESP with ACK.
    - Otherwise -> DATA.
  - DATA: each byte is shifted into mem_wdata at bit position 8*byte_idx.
    - On the last byte of a word, the next cycle has mem_we=1, mem_addr=word_idx and the complete word on mem_wdata, for exactly 1 clock.
    - word_idx then increments. Address 0 is the first word; no wrap, because N is bounded above.
    - After word N-1 -> CSUM if enabled, else RESP with ACK.
  - RESP: wait until tx_busy=0, then pulse tx_start for 1 cycle with tx_data = ACK (8'h06) or NAK (8'h15), then go to WAIT_TX.
  - WAIT_TX: wait until tx_busy is seen high and then low.
    - After ACK -> RUN with load_done=1 and stall_pro=0.
    - After NAK -> IDLE with load_err=1 and stall_pro=1.
  - RUN: stall_pro=0. rx_valid with SYNC_BYTE -> CNT_LO, stall_pro=1 from the next cycle, and load_done/load_err cleared. Other bytes are ignored.
- stall_pro is 1 in every state except RUN.
- Timeout: in CNT_LO, CNT_HI, DATA and CSUM, the timer counts clocks since the last rx_valid.
  - When it reaches TIMEOUT_CYC -> RESP with NAK.
  - Words already written stay in memory. The memory is not scrubbed.
- Reset mid-load: all state returns to reset values immediately. Any pending mem_we is dropped, and no partial word is written.
- rx_valid in RESP or WAIT_TX: the byte is dropped.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - The CSUM state expects one byte after the payload, equal to the mod-256 sum of all payload bytes (count bytes excluded).
  - Match -> ACK. Mismatch -> NAK, load_err=1.
  - The checksum accumulator is cleared on SYNC_BYTE.
- Undefined: no CSUM state or accumulator; the payload end goes directly to ACK.

Decomposition:
- Package boot_pkg holds:
  - the state enum (IDLE, CNT_LO, CNT_HI, DATA, CSUM, RESP, WAIT_TX, RUN);
  - ACK_BYTE = 8'h06 and NAK_BYTE = 8'h15;
  - a localparam function computing BYTES_PER_WORD from DATA_W.
- One sub-module, boot_word_pack: byte counter plus shift/assembly register. Outputs a word-complete strobe and the word value; parametrised on DATA_W.

Test Plan:
- Normal load (defaults, checksum enabled):
  - Send A5 02 00 13 00 00 00 93 00 10 00 B6.
  - Expect mem_we at addr 0 with 32'h00000013, then addr 1 with 32'h00100093.
  - Expect tx 06, then stall_pro 1->0 and load_done=1.
- Over-length count:
  - Send A5 01 01 (N=257, ADDR_W=8).
  - Expect no mem_we, tx 15, load_err=1, stall_pro stays 1.
- Bad checksum:
  - Same frame as the normal load, with a final byte of B7.
  - Expect both writes, then tx 15, load_err=1, stall_pro=1.
- Timeout (TIMEOUT_CYC=100):
  - Send A5 02 00 13, then silence.
  - Expect tx 15 once 100 idle cycles have elapsed, and no mem_we.
- Reset mid-load:
  - Assert reset after the 3rd data byte.
  - Expect all outputs at reset values; a subsequent full frame loads correctly.
- Reload from RUN:
  - After a successful load, send A5 01 00 EF BE AD DE.
  - Expect stall_pro high within 1 cycle of the A5, a write at addr 0 of 32'hDEADBEEF, then tx 06 and stall_pro low.
